// File: rtl/wb_pkg.sv
// Shared types for the write-back stage.
//   result_src_e : selector for the write-back result mux
//   wb_state_e   : halt FSM states
package wb_pkg;

  typedef enum logic [1:0] {
    RESULT_SRC_ALU         = 2'd0,
    RESULT_SRC_MEM         = 2'd1,
    RESULT_SRC_PC_PLUS_4   = 2'd2,
    RESULT_SRC_PC_PLUS_IMM = 2'd3
  } result_src_e;

  typedef enum logic [1:0] {
    WB_RUN    = 2'd0,
    WB_DRAIN  = 2'd1,
    WB_HALTED = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_result_mux.sv
// Combinational write-back result select.
// Ports:
//   result_src_i  : 2-bit result selector (wb_pkg::result_src_e encoding)
//   alu_result_i  : ALU result
//   read_data_i   : load data
//   pc_plus_4_i   : link value
//   pc_plus_imm_i : AUIPC value
//   data_o        : selected result (0 for an unrecognised code)
//   legal_o       : selector code is a recognised source
module wb_result_mux
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]      result_src_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [XLEN-1:0] read_data_i,
  input  logic [XLEN-1:0] pc_plus_4_i,
  input  logic [XLEN-1:0] pc_plus_imm_i,
  output logic [XLEN-1:0] data_o,
  output logic            legal_o
);

  result_src_e src;
  assign src = result_src_e'(result_src_i);

  always_comb begin
    data_o  = '0;
    legal_o = 1'b1;
    case (src)
      RESULT_SRC_ALU:         data_o = alu_result_i;
      RESULT_SRC_MEM:         data_o = read_data_i;
      RESULT_SRC_PC_PLUS_4:   data_o = pc_plus_4_i;
      RESULT_SRC_PC_PLUS_IMM: data_o = pc_plus_imm_i;
      // Every 2-bit code is currently assigned; kept so a future reserved code is safe.
      default: begin
        data_o  = '0;
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/write_back_unit.sv
// Registered final pipeline stage: accepts a completed instruction via valid/ready, selects its
// result and drives the register-file write port one cycle later. Includes a halt FSM
// (RUN -> DRAIN -> HALTED), a retired-instruction counter and sticky status flags.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : upstream handshake; in_ready depends on state only
//   alu_result, read_data, pc_plus_4, pc_plus_imm : candidate results
//   result_src           : result selector
//   rd_addr, reg_write   : destination register and write intent
//   stop_pipeline        : instruction is the halt marker
//   rf_we, rf_waddr, rf_wdata : registered register-file write port
//   instret              : retired-instruction count (wraps)
//   halted               : stage stopped, sticky until reset
//   src_error            : sticky, illegal selector seen on a writing instruction
module write_back_unit
  import wb_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       alu_result,
  input  logic [XLEN-1:0]       read_data,
  input  logic [XLEN-1:0]       pc_plus_4,
  input  logic [XLEN-1:0]       pc_plus_imm,
  input  logic [1:0]            result_src,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  reg_write,
  input  logic                  stop_pipeline,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic [CNT_W-1:0]      instret,
  output logic                  halted,
  output logic                  src_error
);

  wb_state_e             state_q, state_d;
  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;
  logic [CNT_W-1:0]      instret_q, instret_d;
  logic                  src_error_q, src_error_d;

  logic [XLEN-1:0] mux_data;
  logic            mux_legal;
  logic            accept;

  wb_result_mux #(
    .XLEN(XLEN)
  ) u_result_mux (
    .result_src_i (result_src),
    .alu_result_i (alu_result),
    .read_data_i  (read_data),
    .pc_plus_4_i  (pc_plus_4),
    .pc_plus_imm_i(pc_plus_imm),
    .data_o       (mux_data),
    .legal_o      (mux_legal)
  );

  // Ready is a pure function of state so no path exists from in_valid back to in_ready.
  assign in_ready = (state_q == WB_RUN);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    instret_d   = instret_q;
    src_error_d = src_error_q;

    if (accept) begin
      rf_we_d     = reg_write & (rd_addr != '0) & mux_legal;
      rf_waddr_d  = rd_addr;
      rf_wdata_d  = mux_data;
      instret_d   = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
      src_error_d = src_error_q | (reg_write & ~mux_legal);
    end

    case (state_q)
      WB_RUN:    if (accept && stop_pipeline) state_d = WB_DRAIN;
      // Halt marker's own write is presented on the port during this cycle.
      WB_DRAIN:  state_d = WB_HALTED;
      WB_HALTED: state_d = WB_HALTED;
      default:   state_d = WB_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= WB_RUN;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      instret_q   <= '0;
      src_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      instret_q   <= instret_d;
      src_error_q <= src_error_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign instret   = instret_q;
  assign halted    = (state_q == WB_HALTED);
  assign src_error = src_error_q;

endmodule

// File: tb/tb_write_back_unit.sv
// Bench for write_back_unit: a default build (64-bit counter) and a CNT_W=4 build share one
// stimulus stream. Expected values come from a cycle-level behavioural model kept here.
module tb_write_back_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] alu_result, read_data, pc_plus_4, pc_plus_imm;
  logic [1:0]  result_src;
  logic [4:0]  rd_addr;
  logic        reg_write, stop_pipeline;

  logic        in_ready, rf_we, halted, src_error;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [63:0] instret;

  logic        in_ready4, rf_we4, halted4, src_error4;
  logic [4:0]  rf_waddr4;
  logic [31:0] rf_wdata4;
  logic [3:0]  instret4;

  int tests = 0;
  int fails = 0;

  // Model state: phase 0 = running, 1 = draining, 2 = halted.
  int          m_phase;
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  longint unsigned m_cnt;
  int          m_cnt4;

  always #5 clk = ~clk;

  write_back_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .read_data(read_data), .pc_plus_4(pc_plus_4),
    .pc_plus_imm(pc_plus_imm), .result_src(result_src), .rd_addr(rd_addr),
    .reg_write(reg_write), .stop_pipeline(stop_pipeline), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .instret(instret), .halted(halted),
    .src_error(src_error)
  );

  write_back_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .alu_result(alu_result), .read_data(read_data), .pc_plus_4(pc_plus_4),
    .pc_plus_imm(pc_plus_imm), .result_src(result_src), .rd_addr(rd_addr),
    .reg_write(reg_write), .stop_pipeline(stop_pipeline), .rf_we(rf_we4),
    .rf_waddr(rf_waddr4), .rf_wdata(rf_wdata4), .instret(instret4), .halted(halted4),
    .src_error(src_error4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit v, input int src, input int rd, input bit we, input bit stop,
                        input logic [31:0] a, input logic [31:0] m, input logic [31:0] p4,
                        input logic [31:0] pi);
    in_valid = v; result_src = 2'(src); rd_addr = 5'(rd); reg_write = we;
    stop_pipeline = stop; alu_result = a; read_data = m; pc_plus_4 = p4; pc_plus_imm = pi;
  endtask

  // Advance one clock with the current inputs, update the model, compare all outputs.
  task automatic step();
    bit          ready, acc;
    logic [31:0] sel;
    ready = (m_phase == 0);
    check("in_ready", 64'(in_ready), 64'(ready));
    check("in_ready4", 64'(in_ready4), 64'(ready));
    acc = in_valid && ready;
    case (result_src)
      2'd0: sel = alu_result;
      2'd1: sel = read_data;
      2'd2: sel = pc_plus_4;
      default: sel = pc_plus_imm;
    endcase
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_phase = 0; m_we = 0; m_waddr = '0; m_wdata = '0; m_cnt = 0; m_cnt4 = 0;
    end else begin
      m_we = 0;
      if (m_phase == 1) m_phase = 2;
      if (acc) begin
        m_we    = reg_write && (rd_addr != 0);
        m_waddr = rd_addr;
        m_wdata = sel;
        m_cnt   = m_cnt + 1;
        m_cnt4  = (m_cnt4 + 1) % 16;
        if (stop_pipeline) m_phase = 1;
      end
    end
    check("rf_we", 64'(rf_we), 64'(m_we));
    check("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
    check("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
    check("instret", instret, m_cnt);
    check("instret4", 64'(instret4), 64'(m_cnt4));
    check("halted", 64'(halted), 64'(m_phase == 2));
    check("src_error", 64'(src_error), 64'd0);
    check("rf_we4", 64'(rf_we4), 64'(m_we));
  endtask

  initial begin
    m_phase = 0; m_we = 0; m_waddr = '0; m_wdata = '0; m_cnt = 0; m_cnt4 = 0;
    rst_n = 1'b0;
    set_in(1, 0, 3, 1, 0, 32'h55, 32'h66, 32'h77, 32'h88);
    #1;

    // 1. Reset held three cycles with in_valid high.
    repeat (3) step();
    check("rst_instret", instret, 64'd0);
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_ready", 64'(in_ready), 64'd1);

    // 2. Single ALU write.
    set_in(1, 0, 5, 1, 0, 32'h1234, 32'h0, 32'h0, 32'h0);
    step();
    check("t2_wdata", 64'(rf_wdata), 64'h1234);
    check("t2_count", instret, 64'd1);

    // 3. Four back-to-back, one per source.
    set_in(1, 0, 1, 1, 0, 32'hA, 32'h0, 32'h0, 32'h0);  step();
    set_in(1, 1, 2, 1, 0, 32'h0, 32'hB, 32'h0, 32'h0);  step();
    set_in(1, 2, 3, 1, 0, 32'h0, 32'h0, 32'hC, 32'h0);  step();
    set_in(1, 3, 4, 1, 0, 32'h0, 32'h0, 32'h0, 32'hD);  step();
    check("t3_last", 64'(rf_wdata), 64'hD);

    // 4. Write to x0 is dropped but retires.
    set_in(1, 0, 0, 1, 0, 32'hFFFF, 32'h0, 32'h0, 32'h0);
    step();
    check("t4_x0_we", 64'(rf_we), 64'd0);

    // 5. Halt marker, then ignored pulses.
    set_in(1, 2, 7, 1, 1, 32'h0, 32'h0, 32'h100, 32'h0);
    step();
    check("t5_drain_wdata", 64'(rf_wdata), 64'h100);
    for (int i = 0; i < 4; i++) begin
      set_in(i % 2 == 0, 0, 9, 1, 0, 32'h999, 32'h0, 32'h0, 32'h0);
      step();
    end
    check("t5_halted", 64'(halted), 64'd1);

    // 6. Reset while halted, then 17 accepts wrap the 4-bit counter to 1.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      set_in(1, i % 4, i % 32, i % 3 != 0, 0, 32'(i), 32'(i + 100), 32'(i + 200), 32'(i + 300));
      step();
    end
    check("t6_wrap", 64'(instret4), 64'd1);
    check("t6_full", instret, 64'd17);

    // Randomized traffic with occasional halts and resets.
    for (int i = 0; i < 400; i++) begin
      rst_n = !((m_phase == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0);
      set_in($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
             $urandom_range(0, 4) != 0, $urandom_range(0, 29) == 0,
             $urandom, $urandom, $urandom, $urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
